// File: rtl/counter_down_mod_n.sv
// Modulo-N down counter with load, terminal-count flag, wrap pulse and
// a saturating 8-bit tally of wraps.
//
// Each edge follows the priority reset > load > en > hold. Counting down
// from 0 wraps to N-1, raises a one-cycle wrap pulse and bumps the tally.
// A load above N-1 is clamped to N-1, so count always stays within 0..N-1.
module counter_down_mod_n #(
  parameter int WIDTH = 5,
  parameter int N     = 20
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             wrap,
  output logic [7:0]       wraps
);

  // Top value of the count range, at count width and one bit wider so the
  // clamp compare still works when N == 2^WIDTH.
  localparam logic [WIDTH-1:0] TopValue    = WIDTH'(N - 1);
  localparam logic [WIDTH:0]   TopValueExt = (WIDTH + 1)'(N - 1);

  logic [WIDTH-1:0] r_count;
  logic             r_wrap;
  logic [7:0]       r_wraps;

  logic             w_loadTooBig;
  logic [WIDTH-1:0] w_loadClamped;
  logic             w_atZero;
  logic             w_tallyFull;

  // Load-value clamp and the zero / tally-full flags that feed the register.
  always_comb begin
    w_loadTooBig  = ({1'b0, load_val} > TopValueExt);
    w_loadClamped = w_loadTooBig ? TopValue : load_val;
    w_atZero      = (r_count == '0);
    w_tallyFull   = (r_wraps == 8'hFF);
  end

  // Count, wrap pulse and wrap tally, updated by priority each rising edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= TopValue;
      r_wrap  <= 1'b0;
      r_wraps <= 8'h00;
    end else if (load) begin
      r_count <= w_loadClamped;
      r_wrap  <= 1'b0;
    end else if (en) begin
      if (w_atZero) begin
        r_count <= TopValue;
        r_wrap  <= 1'b1;
        if (!w_tallyFull) begin
          r_wraps <= r_wraps + 8'd1;
        end
      end else begin
        r_count <= r_count - WIDTH'(1);
        r_wrap  <= 1'b0;
      end
    end else begin
      r_wrap <= 1'b0;
    end
  end

  assign count = r_count;
  assign tc    = w_atZero;
  assign wrap  = r_wrap;
  assign wraps = r_wraps;

endmodule

// File: doc/counter_down_mod_n.md
COUNTER_DOWN_MOD_N -- requirements
Module: counter_down_mod_n

Interface
REQ-001 The block SHALL have parameter WIDTH, default 5, giving the count width in bits.
REQ-002 The block SHALL have parameter N, default 20, giving the modulus; 2 <= N <= 2^WIDTH.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port en, input, 1 bit: count enable.
REQ-006 The block SHALL have port load, input, 1 bit: load request.
REQ-007 The block SHALL have port load_val, input, WIDTH bits: the value to load.
REQ-008 The block SHALL have port count, output, WIDTH bits: the current count, registered.
REQ-009 The block SHALL have port tc, output, 1 bit: terminal count, high while count == 0.
REQ-010 The block SHALL have port wrap, output, 1 bit: a one-cycle pulse on each 0 -> N-1 transition.
REQ-011 The block SHALL have port wraps, output, 8 bits: a saturating tally of wrap events.

Function
REQ-012 Priority per edge SHALL be reset > load > en > hold.
REQ-013 If load = 1 and load_val <= N-1, count SHALL become load_val on the next edge.
REQ-014 If load = 1 and load_val >= N, count SHALL become N-1 (clamped).
REQ-015 A load SHALL NOT assert wrap and SHALL NOT change wraps.
REQ-016 If en = 1, load = 0 and count > 0, count SHALL decrement by 1 on the next edge.
REQ-017 If en = 1, load = 0 and count == 0, then on the next edge:
- count SHALL become N-1;
- wrap SHALL be high for exactly that one cycle;
- wraps SHALL increment by 1.
REQ-018 wraps SHALL saturate at 255: a wrap event at 255 leaves it at 255, while count and wrap still behave normally.
REQ-019 If en = 0 and load = 0, count and wraps SHALL hold and wrap SHALL be 0.
REQ-020 tc SHALL be combinational from the count register (count == 0), with no added cycle of latency.
REQ-021 wrap SHALL be a registered output, aligned with the cycle in which count first shows N-1 after the wrap.
REQ-022 count SHALL never leave the range 0..N-1 under any input sequence.
REQ-023 en toggling SHALL cause no skipped or repeated values: each enabled edge moves count by exactly one step.
REQ-024 When load and en are both 1, only the load SHALL take effect in that cycle.

Reset
REQ-025 When reset = 1 at an edge, on that edge:
- count SHALL become N-1;
- wrap SHALL become 0;
- wraps SHALL become 0.
REQ-026 tc SHALL be 0 after reset, since N >= 2.
REQ-027 Reset asserted mid-count or in the wrap cycle SHALL override all other inputs, and the wrap pulse SHALL be cancelled.
REQ-028 Outputs SHALL be undefined before the first reset edge; the bench SHALL apply reset before any checks.

Verification
REQ-029 Scenario: reset for 5 cycles, then en = 1 for 25 cycles -> count runs 19, 18, ..., 0, 19, 18, 17, 16, 15.
- The bench SHALL check one wrap pulse at the first 19 after 0, and wraps = 1.
- The bench SHALL check tc high only in the cycle count == 0.
REQ-030 Scenario: count = 7, then en = 0 for 5 cycles, then en = 1 -> count holds at 7, wrap = 0, and the next value is 6.
REQ-031 Scenario: load = 1 with load_val = 3 -> count = 3.
- Then load_val = 25 -> count = 19.
- Then load_val = 0 -> count = 0 and tc = 1; wraps is unchanged throughout.
REQ-032 Scenario: load = 1 and en = 1 in the same cycle with load_val = 10 -> count = 10, not 9 and not a decrement of the old value.
REQ-033 Scenario: reset pulsed in the cycle where count == 0 with en = 1 -> count = 19, wrap stays 0, wraps = 0.
REQ-034 Scenario: more than 255 wraps with N = 2 (about 520 enabled cycles) -> wraps = 255 and stays there, while wrap keeps pulsing every 2nd cycle.
